// File: rtl/softmax_pkg.sv
// Shared defaults and FSM encoding for the softmax vector reader.
package softmax_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_NUM_CLASSES = 1000;
  localparam int DEF_PTR_WIDTH   = 13;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/softmax_skid_buf.sv
// Two-entry skid buffer carrying an element and its end-of-vector flag.
module softmax_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] data,
  output logic         last
);

  logic [1:0]   count;
  logic [W-1:0] head_data, tail_data;
  logic         head_last, tail_last;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign data  = head_data;
  assign last  = head_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      head_data <= '0;
      tail_data <= '0;
      head_last <= 1'b0;
      tail_last <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= push_data;
            head_last <= push_last;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= push_data;
            head_last <= push_last;
          end else if (push) begin
            tail_data <= push_data;
            tail_last <= push_last;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_data <= tail_data;
            head_last <= tail_last;
            if (push) begin
              tail_data <= push_data;
              tail_last <= push_last;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/softmax_stream_reader.sv
// Reads one vector from the score buffer, streams it downstream and tracks the
// signed argmax of the elements delivered.
module softmax_stream_reader
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int PTR_WIDTH   = DEF_PTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_clr,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_inc,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic [PTR_WIDTH-1:0]  max_index
);

  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(NUM_CLASSES - 1);

  state_t                state, state_nxt;
  logic [PTR_WIDTH-1:0]  rd_cnt, out_cnt;
  logic                  rd_pend, rd_last_pend;
  logic                  rd_en, pop;
  logic                  sk_full, sk_empty, sk_last;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [1:0]            occ;
  logic [2:0]            budget;

  softmax_skid_buf #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (fifo_data),
    .push_last (rd_last_pend),
    .pop       (pop),
    .full      (sk_full),
    .empty     (sk_empty),
    .data      (sk_data),
    .last      (sk_last)
  );

  assign m_valid = !sk_empty;
  assign m_data  = sk_empty ? '0 : sk_data;
  assign m_last  = !sk_empty && sk_last;
  assign pop     = m_valid && m_ready;

  // Slots committed after this cycle: what survives the pop plus the read landing now.
  assign occ    = sk_full ? 2'd2 : (sk_empty ? 2'd0 : 2'd1);
  assign budget = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_pend};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = CLR;
      CLR:    state_nxt = STREAM;
      STREAM: begin
        if (budget < 3'd2) begin
          rd_en = 1'b1;
          if (rd_cnt == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN:  if (!rd_pend && sk_empty) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en  = rd_en;
  assign fifo_rd_inc = rd_en;
  assign fifo_rd_clr = (state == CLR);
  assign done        = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      out_cnt      <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      max_value    <= '0;
      max_index    <= '0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= rd_en;
      rd_last_pend <= rd_en && (rd_cnt == LAST_IDX);
      if (state == CLR) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + 1'b1;
        if (pop && out_cnt != LAST_IDX) out_cnt <= out_cnt + 1'b1;
      end
      if (pop && (out_cnt == '0 || $signed(m_data) > $signed(max_value))) begin
        max_value <= m_data;
        max_index <= out_cnt;
      end
    end
  end

endmodule
